// File: rtl/status_led_bank.sv
// Multi-channel status LED driver: off/on/fast/slow blink and burst-code modes sharing one prescaler and phase counter.
// Optional PWM dimming through the brightness port is enabled with `define STATUS_LED_PWM_EN.
module status_led_bank #(
   parameter int CHANNELS  = 4,
   parameter int CLK_HZ    = 25000000,
   parameter int TICK_HZ   = 8,
   parameter int GAP_TICKS = 6
) (
   input  logic                    clock_25mhz,
   input  logic                    reset_sync,
   input  logic [3*CHANNELS-1:0]   mode,
   input  logic [3*CHANNELS-1:0]   burst_count,
   input  logic [3:0]              brightness,
   output logic                    tick,
   output logic [CHANNELS-1:0]     led
);

   localparam int PRESC_DIV = CLK_HZ / TICK_HZ;
   localparam int PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
   localparam logic [5:0] GAP_LEN = 6'(GAP_TICKS);

   localparam logic [2:0] MODE_OFF   = 3'b000;
   localparam logic [2:0] MODE_ON    = 3'b001;
   localparam logic [2:0] MODE_FAST  = 3'b010;
   localparam logic [2:0] MODE_SLOW  = 3'b011;
   localparam logic [2:0] MODE_BURST = 3'b100;

   if (PRESC_DIV < 2) begin : gDivCheck
      $error("status_led_bank: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (GAP_TICKS < 1 || GAP_TICKS > 15) begin : gGapCheck
      $error("status_led_bank: GAP_TICKS must be in 1..15");
   end

   logic [PRESC_W-1:0]  prescCnt_q;
   logic [2:0]          phase_q;
   logic                tick_q;
   logic                tickEvt;
   logic [CHANNELS-1:0] ledRaw;
   logic [CHANNELS-1:0] led_d;
   logic [CHANNELS-1:0] led_q;

   // The internal tick fires on the wrap edge itself, so phase and step move together with the tick output.
   assign tickEvt = (prescCnt_q == PRESC_LAST);

   always_ff @(posedge clock_25mhz or posedge reset_sync) begin
      if (reset_sync) begin
         prescCnt_q <= '0;
         phase_q    <= '0;
         tick_q     <= 1'b0;
      end else begin
         tick_q <= tickEvt;
         if (tickEvt) begin
            prescCnt_q <= '0;
            phase_q    <= phase_q + 3'd1;
         end else begin
            prescCnt_q <= prescCnt_q + PRESC_W'(1);
         end
      end
   end

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : gCh
      logic [2:0] chMode;
      logic [2:0] chCount;
      logic [5:0] flashLen;
      logic [5:0] seqLen;
      logic [3:0] step_q;
      logic [3:0] step_d;
      logic       burstLit;
      logic       chLit;

      assign chMode   = mode[3*ch +: 3];
      assign chCount  = burst_count[3*ch +: 3];
      assign flashLen = {2'b00, chCount, 1'b0};
      assign seqLen   = flashLen + GAP_LEN;
      assign burstLit = ({2'b00, step_q} < flashLen) && !step_q[0];

      // A new burst_count takes effect at once; an out-of-range step simply wraps on the next tick.
      always_comb begin
         step_d = step_q;
         if (chMode != MODE_BURST) begin
            step_d = '0;
         end else if (tickEvt) begin
            if ({2'b00, step_q} >= (seqLen - 6'd1)) begin
               step_d = '0;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
      end

      always_ff @(posedge clock_25mhz or posedge reset_sync) begin
         if (reset_sync) begin
            step_q <= '0;
         end else begin
            step_q <= step_d;
         end
      end

      always_comb begin
         chLit = 1'b0;
         case (chMode)
            MODE_OFF:   chLit = 1'b0;
            MODE_ON:    chLit = 1'b1;
            MODE_FAST:  chLit = ~phase_q[0];
            MODE_SLOW:  chLit = phase_q[2];
            MODE_BURST: chLit = burstLit;
            default:    chLit = 1'b0;
         endcase
      end

      assign ledRaw[ch] = chLit;
   end

`ifdef STATUS_LED_PWM_EN
   logic [3:0] pwmCnt_q;
   logic       pwmGate;

   always_ff @(posedge clock_25mhz or posedge reset_sync) begin
      if (reset_sync) begin
         pwmCnt_q <= '0;
      end else begin
         pwmCnt_q <= pwmCnt_q + 4'd1;
      end
   end

   assign pwmGate = (pwmCnt_q < brightness);
   assign led_d   = ledRaw & {CHANNELS{pwmGate}};
`else
   logic unusedBrightness;

   assign unusedBrightness = ^brightness;
   assign led_d            = ledRaw;
`endif

   always_ff @(posedge clock_25mhz or posedge reset_sync) begin
      if (reset_sync) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign tick = tick_q;
   assign led  = led_q;

endmodule
